// File: rtl/rgb_to_hsv.sv
// Purpose: converts an 8-bit RGB pixel stream into 8-bit HSV with video timing carried alongside.
// Latency: 5 enabled clock edges from R/G/B/timing inputs to H/S/V/timing outputs, one pixel per enabled clock.
// Backpressure: none; ce=0 freezes every stage and the outputs, ce=1 advances the whole pipeline.
module rgb_to_hsv (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic       in_de,
    output logic [7:0] H,
    output logic [7:0] S,
    output logic [7:0] V,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_de
);

    // Stage 1: registered copy of the input pixel
    logic [7:0]  r1, g1, b1;

    // Stage 2: extrema, hue sector offset and signed hue numerator (sign + magnitude)
    logic [7:0]  mx2, dlt2, off2, mag2;
    logic        neg2;

    // Stage 3: the two dividends (43*|n| and 255*delta) with their divisors
    logic [15:0] hnum3, snum3;
    logic [7:0]  mx3, dlt3, off3;
    logic        neg3;

    // Stage 4: quotients; both are bounded to 8 bits because |n| <= delta <= max
    logic [7:0]  hq4, sq4, v4, off4;
    logic        neg4, gray4;

    // Timing delay line, one 3-bit slot per pipeline stage
    logic [4:0][2:0] tdly;

    // Combinational helpers for stage 2
    logic [7:0]  mx_c, mn_c, off_c, na_c, nb_c;

    // Find max/min and pick the dominant channel with R > G > B priority
    always_comb begin
        mx_c = r1;
        if (g1 > mx_c) mx_c = g1;
        if (b1 > mx_c) mx_c = b1;
        mn_c = r1;
        if (g1 < mn_c) mn_c = g1;
        if (b1 < mn_c) mn_c = b1;
        off_c = 8'd0;
        na_c  = g1;
        nb_c  = b1;
        if (r1 == mx_c) begin
            off_c = 8'd0;
            na_c  = g1;
            nb_c  = b1;
        end else if (g1 == mx_c) begin
            off_c = 8'd85;
            na_c  = b1;
            nb_c  = r1;
        end else begin
            off_c = 8'd171;
            na_c  = r1;
            nb_c  = g1;
        end
    end

    // Pixel pipeline: every stage loads only on an enabled edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1    <= '0;
            g1    <= '0;
            b1    <= '0;
            mx2   <= '0;
            dlt2  <= '0;
            off2  <= '0;
            mag2  <= '0;
            neg2  <= 1'b0;
            hnum3 <= '0;
            snum3 <= '0;
            mx3   <= '0;
            dlt3  <= '0;
            off3  <= '0;
            neg3  <= 1'b0;
            hq4   <= '0;
            sq4   <= '0;
            v4    <= '0;
            off4  <= '0;
            neg4  <= 1'b0;
            gray4 <= 1'b0;
            H     <= '0;
            S     <= '0;
            V     <= '0;
        end else if (ce) begin
            r1    <= R;
            g1    <= G;
            b1    <= B;

            mx2   <= mx_c;
            dlt2  <= mx_c - mn_c;
            off2  <= off_c;
            neg2  <= (na_c < nb_c);
            mag2  <= (na_c < nb_c) ? (nb_c - na_c) : (na_c - nb_c);

            hnum3 <= 16'(mag2) * 16'd43;
            snum3 <= 16'(dlt2) * 16'd255;
            mx3   <= mx2;
            dlt3  <= dlt2;
            off3  <= off2;
            neg3  <= neg2;

            hq4   <= (dlt3 == 8'd0) ? 8'd0 : 8'(hnum3 / 16'(dlt3));
            sq4   <= (mx3 == 8'd0)  ? 8'd0 : 8'(snum3 / 16'(mx3));
            v4    <= mx3;
            off4  <= off3;
            neg4  <= neg3;
            gray4 <= (dlt3 == 8'd0);

            // 8-bit add/subtract gives the mod-256 hue wrap for free
            H     <= gray4 ? 8'd0 : (neg4 ? (off4 - hq4) : (off4 + hq4));
            S     <= sq4;
            V     <= v4;
        end
    end

    // Timing signals ride a delay line of the same depth as the pixel path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdly <= '0;
        end else if (ce) begin
            tdly <= {tdly[3:0], {in_hsync, in_vsync, in_de}};
        end
    end

    assign out_hsync = tdly[4][2];
    assign out_vsync = tdly[4][1];
    assign out_de    = tdly[4][0];

endmodule

// File: tb/tb_rgb_to_hsv.sv
module tb_rgb_to_hsv;

    logic       clk = 1'b0;
    logic       rst_n, ce;
    logic [7:0] R, G, B, H, S, V;
    logic       in_hsync, in_vsync, in_de;
    logic       out_hsync, out_vsync, out_de;

    always #5 clk = ~clk;

    rgb_to_hsv dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .R(R), .G(G), .B(B),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .H(H), .S(S), .V(V),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de)
    );

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] s;
        logic [7:0] v;
        logic       hs;
        logic       vs;
        logic       de;
    } pix_t;

    typedef struct {
        int r, g, b, hs, vs, de, h, s, v;
    } vec_t;

    pix_t exp_q[$];
    pix_t act;
    int   total = 0;
    int   bad   = 0;

    assign act = {H, S, V, out_hsync, out_vsync, out_de};

    // Reference HSV from the arithmetic definition using plain integers
    function automatic pix_t model(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                   input logic hs, input logic vs, input logic de);
        int ri, gi, bi, mx, mn, d, n, off, q, h;
        pix_t p;
        ri = r; gi = g; bi = b;
        mx = ri; if (gi > mx) mx = gi; if (bi > mx) mx = bi;
        mn = ri; if (gi < mn) mn = gi; if (bi < mn) mn = bi;
        d  = mx - mn;
        h  = 0;
        if (d != 0) begin
            if (ri == mx)      begin off = 0;   n = gi - bi; end
            else if (gi == mx) begin off = 85;  n = bi - ri; end
            else               begin off = 171; n = ri - gi; end
            q = (43 * (n < 0 ? -n : n)) / d;
            h = off + (n < 0 ? -q : q);
            h = ((h % 256) + 256) % 256;
        end
        p.h  = 8'(h);
        p.s  = (mx == 0) ? 8'd0 : 8'((255 * d) / mx);
        p.v  = 8'(mx);
        p.hs = hs;
        p.vs = vs;
        p.de = de;
        return p;
    endfunction

    task automatic check(input string name, input pix_t a, input pix_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got H=%0d S=%0d V=%0d hs/vs/de=%b%b%b, expected H=%0d S=%0d V=%0d hs/vs/de=%b%b%b",
                     name, a.h, a.s, a.v, a.hs, a.vs, a.de, e.h, e.s, e.v, e.hs, e.vs, e.de);
        end
    endtask

    // Present one pixel for the next enabled edge and queue its expected result
    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic hs, input logic vs, input logic de, input pix_t e);
        @(negedge clk);
        R = r; G = g; B = b;
        in_hsync = hs; in_vsync = vs; in_de = de;
        ce = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_rand();
        logic [7:0] r, g, b;
        logic [2:0] t;
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
        // Bias some pixels toward ties and grays to exercise priority and delta=0
        case ($urandom_range(0, 5))
            0: g = r;
            1: b = g;
            2: begin g = r; b = r; end
            default: ;
        endcase
        t = 3'($urandom);
        send(r, g, b, t[2], t[1], t[0], model(r, g, b, t[2], t[1], t[0]));
    endtask

    // Disabled cycles with garbage on the inputs; nothing should be sampled
    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk);
            ce = 1'b0;
            R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
            {in_hsync, in_vsync, in_de} = 3'($urandom);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_async", act, '0);
        repeat (3) begin
            @(negedge clk);
            ce = 1'b1;
            R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
            {in_hsync, in_vsync, in_de} = 3'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ce    = 1'b0;
    endtask

    // Monitor: after each edge, compare outputs against the scoreboard
    logic ce_s, rst_s;
    int   en_cnt = 0;
    pix_t last_exp = '0;
    pix_t e_pop;

    initial begin
        forever begin
            @(posedge clk);
            ce_s  = ce;
            rst_s = rst_n;
            #1;
            if (!rst_s) begin
                en_cnt   = 0;
                last_exp = '0;
                check("in_reset", act, '0);
            end else if (ce_s) begin
                en_cnt++;
                if (en_cnt < 5) begin
                    check("pipe_fill", act, '0);
                end else if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL underflow: output at enabled edge %0d has no expected entry", en_cnt);
                end else begin
                    e_pop    = exp_q.pop_front();
                    last_exp = e_pop;
                    check("pixel", act, e_pop);
                end
            end else begin
                check("ce_hold", act, last_exp);
            end
        end
    end

    vec_t vecs[7] = '{
        '{101, 100, 101, 1, 1, 1, 213,   2, 101},
        '{192, 100,  98, 0, 0, 0,   0, 124, 192},
        '{  0,   0,   0, 1, 0, 1,   0,   0,   0},
        '{128, 128, 128, 0, 1, 0,   0,   0, 128},
        '{  0, 255,   0, 1, 1, 0,  85, 255, 255},
        '{  0,   0, 255, 0, 1, 1, 171, 255, 255},
        '{255, 255,   0, 1, 0, 0,  43, 255, 255}
    };

    initial begin
        pix_t e;
        rst_n = 1'b0;
        ce    = 1'b0;
        R = '0; G = '0; B = '0;
        in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
        #1;
        check("reset_init", act, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed colours, back to back
        foreach (vecs[i]) begin
            e.h  = 8'(vecs[i].h);
            e.s  = 8'(vecs[i].s);
            e.v  = 8'(vecs[i].v);
            e.hs = vecs[i].hs[0];
            e.vs = vecs[i].vs[0];
            e.de = vecs[i].de[0];
            send(8'(vecs[i].r), 8'(vecs[i].g), 8'(vecs[i].b),
                 vecs[i].hs[0], vecs[i].vs[0], vecs[i].de[0], e);
        end

        // Continuous random stream
        repeat (150) send_rand();

        // Long freeze mid-stream, then resume
        hold(10);
        repeat (50) send_rand();

        // Random ce gaps
        repeat (200) begin
            if ($urandom_range(0, 3) == 0) hold($urandom_range(1, 3));
            else send_rand();
        end

        // Reset with pixels in flight, then restart
        repeat (3) send_rand();
        mid_reset();
        hold(2);
        repeat (100) send_rand();
        hold(4);
        repeat (10) send_rand();

        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_to_hsv.md
RGB_TO_HSV -- requirements
Module: rgb_to_hsv

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ce  input  1  clock enable; pipeline advances only on rising clk edges with ce=1.
REQ-005 R, G, B  input  8 each  unsigned pixel components.
REQ-006 in_hsync, in_vsync, in_de  input  1 each  video timing accompanying R/G/B.
REQ-007 H, S, V  output  8 each  unsigned hue, saturation and value of the delayed pixel.
REQ-008 out_hsync, out_vsync, out_de  output  1 each  timing inputs delayed to align with H/S/V.
REQ-009 There SHALL be no parameters; all widths are fixed as listed.

Function
REQ-010 Define max = max(R,G,B), min = min(R,G,B) and delta = max - min, all unsigned 8-bit.
REQ-011 V SHALL equal max.
REQ-012 S SHALL equal floor(255*delta/max), or 0 when max = 0.
REQ-013 The dominant channel SHALL be selected with priority R, then G, then B: R if R = max, else G if G = max, else B.
REQ-014 If delta = 0, H SHALL be 0.
REQ-015 Otherwise H SHALL equal (offset + sign(n)*floor(43*|n|/delta)) mod 256, where:
- R dominant: offset 0, n = G - B.
- G dominant: offset 85, n = B - R.
- B dominant: offset 171, n = R - G.
REQ-016 Intermediate products SHALL be at least 16 bits and the signed numerator at least 9 bits, so no overflow occurs before the final mod-256 wrap.
REQ-017 Division SHALL be exact integer division as defined above; the divider structure is free, but throughput SHALL be one pixel per enabled clock.
REQ-018 Latency SHALL be exactly 5 enabled clock edges from the inputs to H/S/V.
REQ-019 The timing signals SHALL pass through an identical 5-stage delay, so out_hsync/out_vsync/out_de stay aligned with their pixel.
REQ-020 With ce=0, every pipeline register SHALL hold its value and all outputs SHALL remain stable.
REQ-021 Data SHALL be processed regardless of in_de; in_de is only delayed, never used for gating.
REQ-022 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-023 While rst_n=0, all pipeline registers and all outputs (H, S, V, out_hsync, out_vsync, out_de) SHALL be 0 immediately, independent of clk.
REQ-024 After rst_n deasserts, the first valid output SHALL appear 5 enabled edges after the first sampled input.
REQ-025 Asserting reset mid-stream SHALL discard all in-flight pixels.

Verification
REQ-026 R=101,G=100,B=101 with hsync=vsync=de=1, ce=1 -> after 5 edges: H=213, S=2, V=101, out_hsync=out_vsync=out_de=1.
REQ-027 R=192,G=100,B=98 with timing signals 0 -> after 5 edges: H=0, S=124, V=192, all out_* timing signals 0.
REQ-028 Primary and boundary colours:
- (0,0,0) -> H=0, S=0, V=0.
- (128,128,128) -> H=0, S=0, V=128.
- (0,255,0) -> H=85, S=255, V=255.
- (0,0,255) -> H=171, S=255, V=255.
- (255,255,0) -> H=43, S=255, V=255.
REQ-029 Stream of distinct pixels on consecutive cycles -> outputs follow the same sequence 5 cycles later, one per cycle, with timing signals aligned.
REQ-030 Hold ce=0 for 10 cycles mid-stream -> outputs frozen; on ce=1 the sequence resumes with no pixel lost or duplicated.
REQ-031 Pull rst_n low mid-stream -> all outputs 0 immediately; after release the outputs stay 0 until the first new pixel emerges 5 edges later.
